// File: rtl/p4_wb_scheduler_if.sv
// Writeback scheduler bus: MEM/WB writeback, multi-cycle result handshake,
// MEM/WB stall and the register-file write port.
interface p4_wb_scheduler_if;
  logic [2:0]  pipe_type;
  logic [31:0] pipe_data;
  logic [4:0]  pipe_rd;
  logic        mc_valid;
  logic [31:0] mc_data;
  logic [4:0]  mc_rd;
  logic        mc_ready;
  logic        stall_out;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  // Pipeline / multi-cycle unit / register file side
  modport master (
    output pipe_type, pipe_data, pipe_rd, mc_valid, mc_data, mc_rd,
    input  mc_ready, stall_out, rf_we, rf_waddr, rf_wdata
  );

  // Scheduler side
  modport slave (
    input  pipe_type, pipe_data, pipe_rd, mc_valid, mc_data, mc_rd,
    output mc_ready, stall_out, rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/p4_wb_scheduler.sv
// Register-file write-port scheduler. MEM/WB writeback has priority; a blocked
// multi-cycle result waits in a one-entry buffer, and after MAX_WAIT blocked
// cycles MEM/WB is stalled for one cycle so the buffered result can retire.
module p4_wb_scheduler #(
  parameter int unsigned MAX_WAIT = 4,
  parameter logic [7:0]  WB_MASK  = 8'h3F
) (
  input  logic              clock,
  input  logic              reset,
  p4_wb_scheduler_if.slave  bus
);

  localparam int unsigned CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  // IDLE: buffer empty; PEND: buffer holds a blocked result; FORCE: stall cycle
  typedef enum logic [1:0] {IDLE = 2'd0, PEND = 2'd1, FORCE = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [4:0]        buf_rd_q, buf_rd_d;
  logic [31:0]       buf_data_q, buf_data_d;
  logic              rf_we_q, rf_we_d;
  logic [4:0]        rf_waddr_q, rf_waddr_d;
  logic [31:0]       rf_wdata_q, rf_wdata_d;

  logic pipe_wr;
  logic mc_ready_int;
  logic mc_wr;

  assign pipe_wr = WB_MASK[bus.pipe_type] && (bus.pipe_rd != 5'd0);
  // A taken result aimed at x0 is accepted but never written or buffered
  assign mc_wr   = bus.mc_valid && mc_ready_int && (bus.mc_rd != 5'd0);

  // State register, buffer and registered write port
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      buf_rd_q   <= '0;
      buf_data_q <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      buf_rd_q   <= buf_rd_d;
      buf_data_q <= buf_data_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // Next state and write selection for the coming edge
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    buf_rd_d   = buf_rd_q;
    buf_data_d = buf_data_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    case (state_q)
      IDLE: begin
        if (pipe_wr) begin
          rf_we_d    = 1'b1;
          rf_waddr_d = bus.pipe_rd;
          rf_wdata_d = bus.pipe_data;
          // Same rd: the younger pipeline write makes the result obsolete
          if (mc_wr && (bus.mc_rd != bus.pipe_rd)) begin
            buf_rd_d   = bus.mc_rd;
            buf_data_d = bus.mc_data;
            wait_cnt_d = CNT_W'(1);
            state_d    = PEND;
          end
        end else if (mc_wr) begin
          rf_we_d    = 1'b1;
          rf_waddr_d = bus.mc_rd;
          rf_wdata_d = bus.mc_data;
        end
      end
      PEND: begin
        if (!pipe_wr) begin
          rf_we_d    = 1'b1;
          rf_waddr_d = buf_rd_q;
          rf_wdata_d = buf_data_q;
          wait_cnt_d = '0;
          state_d    = IDLE;
        end else begin
          rf_we_d    = 1'b1;
          rf_waddr_d = bus.pipe_rd;
          rf_wdata_d = bus.pipe_data;
          if (bus.pipe_rd == buf_rd_q) begin
            wait_cnt_d = '0;
            state_d    = IDLE;
          end else begin
            if (wait_cnt_q < CNT_MAX) begin
              wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
            if (wait_cnt_q >= CNT_LAST) begin
              state_d = FORCE;
            end
          end
        end
      end
      FORCE: begin
        // MEM/WB is held this cycle, so its contents are re-presented next cycle
        rf_we_d    = 1'b1;
        rf_waddr_d = buf_rd_q;
        rf_wdata_d = buf_data_q;
        wait_cnt_d = '0;
        state_d    = IDLE;
      end
      default: begin
        wait_cnt_d = '0;
        state_d    = IDLE;
      end
    endcase
  end

  // Moore handshake outputs; ready is also held low while reset is asserted
  always_comb begin
    mc_ready_int  = reset && (state_q == IDLE);
    bus.mc_ready  = mc_ready_int;
    bus.stall_out = (state_q == FORCE);
  end

  assign bus.rf_we    = rf_we_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_p4_wb_scheduler.sv
// Directed bench for p4_wb_scheduler with a behavioural writeback model.
module tb_p4_wb_scheduler;

  localparam int          MAXW = 4;
  localparam logic [7:0]  MASK = 8'h3F;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  p4_wb_scheduler_if bus();

  p4_wb_scheduler #(.MAX_WAIT(MAXW), .WB_MASK(MASK)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_miss = 0;

  // Behavioural model: a pending result, how long it has been blocked, and
  // whether the next cycle is the forced retirement.
  logic        m_buf_v = 1'b0;
  logic [4:0]  m_buf_rd = '0;
  logic [31:0] m_buf_data = '0;
  int          m_blocked = 0;
  logic        m_force = 1'b0;
  logic        exp_we = 1'b0;
  logic [4:0]  exp_waddr = '0;
  logic [31:0] exp_wdata = '0;
  logic        exp_addr_chk = 1'b0;

  int dut_log[$];
  int mdl_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic emit(input logic [4:0] a, input logic [31:0] d);
    exp_we = 1'b1;
    exp_waddr = a;
    exp_wdata = d;
    exp_addr_chk = 1'b1;
  endtask

  // Apply the writeback rules to the values present at this clock edge
  task automatic model_edge();
    logic pw;
    pw = MASK[bus.pipe_type] && (bus.pipe_rd != 5'd0);
    exp_we = 1'b0;
    exp_addr_chk = 1'b0;
    if (!rst_n) begin
      m_buf_v = 1'b0; m_blocked = 0; m_force = 1'b0;
      exp_waddr = '0; exp_wdata = '0; exp_addr_chk = 1'b1;
    end else if (m_force) begin
      emit(m_buf_rd, m_buf_data);
      m_buf_v = 1'b0; m_force = 1'b0; m_blocked = 0;
    end else if (m_buf_v) begin
      if (!pw) begin
        emit(m_buf_rd, m_buf_data);
        m_buf_v = 1'b0; m_blocked = 0;
      end else begin
        emit(bus.pipe_rd, bus.pipe_data);
        if (bus.pipe_rd == m_buf_rd) begin
          m_buf_v = 1'b0; m_blocked = 0;
        end else begin
          m_blocked = (m_blocked + 1 > MAXW) ? MAXW : m_blocked + 1;
          if (m_blocked >= MAXW) m_force = 1'b1;
        end
      end
    end else begin
      if (pw) begin
        emit(bus.pipe_rd, bus.pipe_data);
        if (bus.mc_valid && bus.mc_rd != 5'd0 && bus.mc_rd != bus.pipe_rd) begin
          m_buf_v = 1'b1; m_buf_rd = bus.mc_rd; m_buf_data = bus.mc_data; m_blocked = 1;
        end
      end else if (bus.mc_valid && bus.mc_rd != 5'd0) begin
        emit(bus.mc_rd, bus.mc_data);
      end
    end
  endtask

  // One clock: update the model at the edge, compare on the falling edge
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("rf_we", bus.rf_we, exp_we);
    if (exp_we || exp_addr_chk) begin
      chk("rf_waddr", 32'(bus.rf_waddr), 32'(exp_waddr));
      chk("rf_wdata", bus.rf_wdata, exp_wdata);
    end
    chk("mc_ready", bus.mc_ready, rst_n && !m_buf_v);
    chk("stall_out", bus.stall_out, m_force);
    if (bus.rf_we) dut_log.push_back(int'(bus.rf_waddr));
    if (exp_we) mdl_log.push_back(int'(exp_waddr));
  endtask

  task automatic drive(input logic [2:0] t, input logic [4:0] rd, input logic [31:0] d,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    bus.pipe_type = t; bus.pipe_rd = rd; bus.pipe_data = d;
    bus.mc_valid = mv; bus.mc_rd = mrd; bus.mc_data = md;
  endtask

  task automatic bubble();
    drive(3'd7, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  int exp_seq[7] = '{1, 2, 3, 4, 9, 5, 6};

  initial begin
    int idx;
    int stalls;
    logic st;
    logic first;

    // Reset held two cycles with a writing instruction present
    rst_n = 1'b0;
    drive(3'd2, 5'd5, 32'h55, 1'b0, 5'd0, 32'd0);
    step();
    step();
    chk("rst_we", bus.rf_we, 1'b0);
    chk("rst_ready", bus.mc_ready, 1'b0);
    rst_n = 1'b1;
    bubble();
    step();
    chk("ready_after_rst", bus.mc_ready, 1'b1);

    // Multi-cycle bypass while pipeline is idle
    drive(3'd7, 5'd0, 32'd0, 1'b1, 5'd3, 32'hAA);
    step();
    chk("bypass_we", bus.rf_we, 1'b1);
    chk("bypass_addr", 32'(bus.rf_waddr), 32'd3);
    chk("bypass_data", bus.rf_wdata, 32'hAA);
    chk("bypass_ready", bus.mc_ready, 1'b1);
    bubble();
    step();
    chk("bypass_idle_we", bus.rf_we, 1'b0);

    // Starvation: rd=1..6 back to back, result rd=9 offered with rd=1
    dut_log.delete();
    mdl_log.delete();
    idx = 1; stalls = 0; first = 1'b1;
    for (int it = 0; it < 20 && idx <= 6; it++) begin
      st = bus.stall_out;
      drive(3'd0, 5'(idx), 32'h100 + 32'(idx), first, 5'd9, 32'h99);
      first = 1'b0;
      if (st) stalls++;
      step();
      if (!st) idx++;
    end
    chk("force_all_consumed", 32'(idx), 32'd7);
    bubble();
    step();
    chk("force_stall_cycles", 32'(stalls), 32'd1);
    chk("force_dut_count", 32'(dut_log.size()), 32'd7);
    chk("force_model_count", 32'(mdl_log.size()), 32'd7);
    for (int i = 0; i < 7; i++) begin
      if (i < dut_log.size()) chk("force_dut_seq", 32'(dut_log[i]), 32'(exp_seq[i]));
      if (i < mdl_log.size()) chk("force_model_seq", 32'(mdl_log[i]), 32'(exp_seq[i]));
    end

    // Buffered rd=7 overtaken by a pipeline write to rd=7
    drive(3'd0, 5'd2, 32'h222, 1'b1, 5'd7, 32'h77);
    step();
    drive(3'd0, 5'd7, 32'h700, 1'b0, 5'd0, 32'd0);
    step();
    chk("overtake_addr", 32'(bus.rf_waddr), 32'd7);
    chk("overtake_data", bus.rf_wdata, 32'h700);
    chk("overtake_ready", bus.mc_ready, 1'b1);
    bubble();
    step();
    chk("overtake_dropped", bus.rf_we, 1'b0);

    // Same rd from both sources in IDLE
    drive(3'd0, 5'd4, 32'h444, 1'b1, 5'd4, 32'h4040);
    step();
    chk("same_rd_we", bus.rf_we, 1'b1);
    chk("same_rd_addr", 32'(bus.rf_waddr), 32'd4);
    chk("same_rd_data", bus.rf_wdata, 32'h444);
    bubble();
    step();
    chk("same_rd_single", bus.rf_we, 1'b0);

    // Non-writing cases: rd=0, masked type, result to x0
    drive(3'd0, 5'd0, 32'h1234, 1'b0, 5'd0, 32'd0);
    step();
    chk("rd0_no_write", bus.rf_we, 1'b0);
    drive(3'd6, 5'd12, 32'h6666, 1'b0, 5'd0, 32'd0);
    step();
    chk("mask_no_write", bus.rf_we, 1'b0);
    drive(3'd7, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD);
    step();
    chk("mc_x0_no_write", bus.rf_we, 1'b0);

    // Buffered result drains on the first free cycle
    drive(3'd1, 5'd11, 32'hB0B, 1'b1, 5'd10, 32'hA0A);
    step();
    bubble();
    step();
    chk("drain_addr", 32'(bus.rf_waddr), 32'd10);
    chk("drain_data", bus.rf_wdata, 32'hA0A);

    // Reset while a result is buffered
    drive(3'd0, 5'd2, 32'h202, 1'b1, 5'd8, 32'h808);
    step();
    rst_n = 1'b0;
    drive(3'd0, 5'd3, 32'h303, 1'b0, 5'd0, 32'd0);
    step();
    chk("pend_rst_we", bus.rf_we, 1'b0);
    chk("pend_rst_stall", bus.stall_out, 1'b0);
    chk("pend_rst_ready", bus.mc_ready, 1'b0);
    rst_n = 1'b1;
    bubble();
    step();
    chk("pend_rst_idle", bus.mc_ready, 1'b1);
    chk("pend_rst_no_buf", bus.rf_we, 1'b0);
    step();
    chk("pend_rst_no_buf2", bus.rf_we, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
